// File: rtl/core_cache_req_buf.sv
// core_cache_req_buf
//   CPU-to-cache request buffer. CPU read/write requests are queued in a
//   DEPTH-entry FIFO. Each head address is split into tag/index/offset, and
//   requests go to the cache in program order. The number of reads waiting
//   for cache data is capped at RD_OUT. Read data comes back to the CPU
//   through a registered response stage.
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   cpu_rd_req_i        CPU read request (address on cpu_rd_addr_i)
//   cpu_wr_req_i        CPU write request (cpu_wr_addr_i/_data_i/_en_i)
//   pipeline_stall_o    a request is present this cycle but not accepted
//   cpu_rd_data_o       registered read data
//   cpu_data_ack_o      one-cycle pulse: cpu_rd_data_o is valid
//   cache_req_o         FIFO head is valid and can be issued
//   cache_op_o          head operation: 0 = read, 1 = write
//   cache_tag_o/_index_o/_offset_o   head address fields
//   cache_wr_en_o       head byte strobes (0 for reads)
//   cache_wr_data_o     head write data
//   cache_addr_ack_i    cache accepts the head, which is then popped
//   cache_rd_data_i     read data from the cache
//   cache_data_ack_i    cache_rd_data_i is valid for the oldest outstanding read
//   err_o               sticky: a data ack arrived with no read outstanding
//
// Optional feature: define CORE_CACHE_BUF_PERF_EN to add perf_stall_cnt_o
//   (cycles with a stall) and perf_req_cnt_o (pops). Both are 32-bit
//   wrapping counters.
module core_cache_req_buf #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int OFFSET_W = 4,
  parameter int INDEX_W  = 8,
  parameter int TAG_W    = 20,
  parameter int DEPTH    = 4,
  parameter int RD_OUT   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_rd_req_i,
  input  logic                  cpu_wr_req_i,
  input  logic [ADDR_W-1:0]     cpu_rd_addr_i,
  input  logic [ADDR_W-1:0]     cpu_wr_addr_i,
  input  logic [DATA_W-1:0]     cpu_wr_data_i,
  input  logic [DATA_W/8-1:0]   cpu_wr_en_i,
  output logic                  pipeline_stall_o,
  output logic [DATA_W-1:0]     cpu_rd_data_o,
  output logic                  cpu_data_ack_o,
  output logic                  cache_req_o,
  output logic                  cache_op_o,
  output logic [TAG_W-1:0]      cache_tag_o,
  output logic [INDEX_W-1:0]    cache_index_o,
  output logic [OFFSET_W-1:0]   cache_offset_o,
  output logic [DATA_W/8-1:0]   cache_wr_en_o,
  output logic [DATA_W-1:0]     cache_wr_data_o,
  input  logic                  cache_addr_ack_i,
  input  logic [DATA_W-1:0]     cache_rd_data_i,
  input  logic                  cache_data_ack_i,
  output logic                  err_o
`ifdef CORE_CACHE_BUF_PERF_EN
  ,
  output logic [31:0]           perf_stall_cnt_o,
  output logic [31:0]           perf_req_cnt_o
`endif
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int RW     = $clog2(RD_OUT + 1);

  // FIFO storage; entry = {op, addr, wdata, wstrb}
  logic              mem_op    [DEPTH];
  logic [ADDR_W-1:0] mem_addr  [DEPTH];
  logic [DATA_W-1:0] mem_wdata [DEPTH];
  logic [STRB_W-1:0] mem_wstrb [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_slot;
  logic [CW-1:0] count;
  logic [RW-1:0] rd_pend;

  logic              empty;
  logic              accept;
  logic              push_wr;
  logic              push_rd;
  logic [1:0]        push_cnt;
  logic              head_op;
  logic [ADDR_W-1:0] head_addr;
  logic              rd_ok;
  logic              pop;
  logic              rd_inc;
  logic              ack_ok;

  assign empty = (count == '0);

  // Free space is judged on the count before this cycle's pop, so a slot
  // being freed right now cannot be reused in the same cycle.
  always_comb begin
    accept = 1'b0;
    if (cpu_rd_req_i && cpu_wr_req_i) begin
      accept = (count <= CW'(DEPTH - 2));
    end else if (cpu_rd_req_i || cpu_wr_req_i) begin
      accept = (count < CW'(DEPTH));
    end
  end

  assign push_wr          = cpu_wr_req_i & accept;
  assign push_rd          = cpu_rd_req_i & accept;
  assign push_cnt         = {1'b0, push_wr} + {1'b0, push_rd};
  assign pipeline_stall_o = (cpu_rd_req_i | cpu_wr_req_i) & ~accept;

  // A paired request stores the write first and the read in the next slot,
  // which keeps the write ahead of the read in issue order.
  assign rd_slot = push_wr ? (wr_ptr + PW'(1)) : wr_ptr;

  always_ff @(posedge clk) begin
    if (push_wr) begin
      mem_op[wr_ptr]    <= 1'b1;
      mem_addr[wr_ptr]  <= cpu_wr_addr_i;
      mem_wdata[wr_ptr] <= cpu_wr_data_i;
      mem_wstrb[wr_ptr] <= cpu_wr_en_i;
    end
    if (push_rd) begin
      mem_op[rd_slot]    <= 1'b0;
      mem_addr[rd_slot]  <= cpu_rd_addr_i;
      mem_wdata[rd_slot] <= '0;
      mem_wstrb[rd_slot] <= '0;
    end
  end

  assign head_op     = mem_op[rd_ptr];
  assign head_addr   = mem_addr[rd_ptr];
  assign rd_ok       = (rd_pend < RW'(RD_OUT));
  assign cache_req_o = ~empty & (head_op | rd_ok);
  assign pop         = cache_req_o & cache_addr_ack_i;
  assign rd_inc      = pop & ~head_op;
  assign ack_ok      = cache_data_ack_i & (rd_pend != '0);

  always_comb begin
    cache_op_o      = 1'b0;
    cache_tag_o     = '0;
    cache_index_o   = '0;
    cache_offset_o  = '0;
    cache_wr_en_o   = '0;
    cache_wr_data_o = '0;
    if (!empty) begin
      cache_op_o      = head_op;
      cache_tag_o     = head_addr[OFFSET_W+INDEX_W +: TAG_W];
      cache_index_o   = head_addr[OFFSET_W +: INDEX_W];
      cache_offset_o  = head_addr[OFFSET_W-1:0];
      cache_wr_en_o   = head_op ? mem_wstrb[rd_ptr] : '0;
      cache_wr_data_o = mem_wdata[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      rd_pend        <= '0;
      err_o          <= 1'b0;
      cpu_data_ack_o <= 1'b0;
      cpu_rd_data_o  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_cnt);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push_cnt) - CW'(pop);

      case ({rd_inc, ack_ok})
        2'b10:   rd_pend <= rd_pend + RW'(1);
        2'b01:   rd_pend <= rd_pend - RW'(1);
        default: rd_pend <= rd_pend;
      endcase

      // A data ack with nothing outstanding is dropped and only flagged.
      if (cache_data_ack_i && (rd_pend == '0)) begin
        err_o <= 1'b1;
      end

      cpu_data_ack_o <= ack_ok;
      if (ack_ok) begin
        cpu_rd_data_o <= cache_rd_data_i;
      end
    end
  end

`ifdef CORE_CACHE_BUF_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt_o <= '0;
      perf_req_cnt_o   <= '0;
    end else begin
      if (pipeline_stall_o) begin
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      end
      if (pop) begin
        perf_req_cnt_o <= perf_req_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule
